// File: rtl/video_timing_gen.sv
// Parametrised raster scan generator: pixel coordinates, data-enable, sync pulses,
// line/frame strobes and a completed-frame counter, all registered and mutually aligned.
module video_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned CW       = 10,
   parameter int unsigned FW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          restart,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          de,
   output logic          hsync,
   output logic          vsync,
   output logic          sol,
   output logic          sof,
   output logic          eof,
   output logic [FW-1:0] frame_cnt
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

   // Elaboration-time guard on the timing parameters.
   if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
       CW == 0 || CW > 31 || FW == 0 ||
       H_TOTAL > (32'd1 << CW) || V_TOTAL > (32'd1 << CW)) begin : g_bad_params
      $error("video_timing_gen: invalid timing parameters");
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] h_nx, v_nx;
   logic [FW-1:0] fc_nx;
   logic          de_nx, hs_nx, vs_nx, sol_nx, sof_nx, eof_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         x         <= '0;
         y         <= '0;
         de        <= 1'b0;
         hsync     <= ~HS_POL;
         vsync     <= ~VS_POL;
         sol       <= 1'b0;
         sof       <= 1'b0;
         eof       <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state     <= state_nx;
         x         <= h_nx;
         y         <= v_nx;
         de        <= de_nx;
         hsync     <= hs_nx;
         vsync     <= vs_nx;
         sol       <= sol_nx;
         sof       <= sof_nx;
         eof       <= eof_nx;
         frame_cnt <= fc_nx;
      end
   end

   // Next position, then decode every flag from that next position so outputs stay aligned.
   always_comb begin
      state_nx = state;
      h_nx     = x;
      v_nx     = y;
      fc_nx    = frame_cnt;
      de_nx    = de;
      hs_nx    = hsync;
      vs_nx    = vsync;
      sol_nx   = sol;
      sof_nx   = sof;
      eof_nx   = eof;

      if (restart) begin
         state_nx = IDLE;
         h_nx     = '0;
         v_nx     = '0;
         de_nx    = 1'b0;
         hs_nx    = ~HS_POL;
         vs_nx    = ~VS_POL;
         sol_nx   = 1'b0;
         sof_nx   = 1'b0;
         eof_nx   = 1'b0;
      end else if (en) begin
         state_nx = RUN;
         if (state == IDLE) begin
            h_nx = '0;
            v_nx = '0;
         end else if (x == H_LAST) begin
            h_nx = '0;
            if (y == V_LAST) begin
               v_nx  = '0;
               fc_nx = frame_cnt + FW'(1);
            end else begin
               v_nx = y + CW'(1);
            end
         end else begin
            h_nx = x + CW'(1);
         end

         de_nx  = (h_nx < H_ACT) && (v_nx < V_ACT);
         hs_nx  = (h_nx >= HS_BEG && h_nx < HS_END) ? HS_POL : ~HS_POL;
         vs_nx  = (v_nx >= VS_BEG && v_nx < VS_END) ? VS_POL : ~VS_POL;
         sol_nx = (h_nx == '0);
         sof_nx = (h_nx == '0) && (v_nx == '0);
         eof_nx = (h_nx == H_LAST) && (v_nx == V_LAST);
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two instances (active-low/wide counter and active-high/2-bit
// counter at the 2^CW boundary) driven in lockstep and checked against a linear pixel-index model.
module tb_video_timing_gen;

   localparam int HT   = 8;
   localparam int VT   = 6;
   localparam int NPIX = HT * VT;

   logic clk = 1'b0;
   logic rst, en, restart;

   logic [3:0]  x0, y0;
   logic        de0, hs0, vs0, sol0, sof0, eof0;
   logic [15:0] fc0;
   logic [2:0]  x1, y1;
   logic        de1, hs1, vs1, sol1, sof1, eof1;
   logic [1:0]  fc1;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: running flag, linear pixel index within the frame, completed frames.
   bit running;
   int pix;
   int frames;

   always #5 clk = ~clk;

   video_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .FW(16)
   ) dut0 (
      .clk(clk), .rst(rst), .en(en), .restart(restart),
      .x(x0), .y(y0), .de(de0), .hsync(hs0), .vsync(vs0),
      .sol(sol0), .sof(sof0), .eof(eof0), .frame_cnt(fc0)
   );

   video_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CW(3), .FW(2)
   ) dut1 (
      .clk(clk), .rst(rst), .en(en), .restart(restart),
      .x(x1), .y(y1), .de(de1), .hsync(hs1), .vsync(vs1),
      .sol(sol1), .sof(sof1), .eof(eof1), .frame_cnt(fc1)
   );

   function automatic logic [5:0] m_flags(input bit pol);
      int hx = pix % HT;
      int vy = pix / HT;
      if (!running) return {1'b0, ~pol, ~pol, 3'b000};
      return {(hx < 4) && (vy < 3),
              (hx >= 5 && hx < 7) ? pol : ~pol,
              (vy == 4) ? pol : ~pol,
              hx == 0, pix == 0, pix == NPIX - 1};
   endfunction

   function automatic logic [29:0] exp0();
      int ex = running ? pix % HT : 0;
      int ey = running ? pix / HT : 0;
      return {4'(ex), 4'(ey), m_flags(1'b0), 16'(frames)};
   endfunction

   function automatic logic [13:0] exp1();
      int ex = running ? pix % HT : 0;
      int ey = running ? pix / HT : 0;
      return {3'(ex), 3'(ey), m_flags(1'b1), 2'(frames)};
   endfunction

   function automatic logic [29:0] obs0();
      return {x0, y0, de0, hs0, vs0, sol0, sof0, eof0, fc0};
   endfunction

   function automatic logic [13:0] obs1();
      return {x1, y1, de1, hs1, vs1, sol1, sof1, eof1, fc1};
   endfunction

   // One clock edge: advance the model with the inputs presented at that edge, then settle.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         running = 1'b0;
         frames  = 0;
      end else if (restart) begin
         running = 1'b0;
      end else if (en) begin
         if (!running) begin
            running = 1'b1;
            pix     = 0;
         end else begin
            pix = (pix + 1) % NPIX;
            if (pix == 0) frames++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; restart = 1'b0;
      running = 1'b0; pix = 0; frames = 0;
      repeat (3) tick();
      n_cmp++;
      if (obs0() !== exp0()) begin
         n_err++; $display("FAIL reset dut0: got %h expected %h", obs0(), exp0());
      end
      n_cmp++;
      if (obs1() !== exp1()) begin
         n_err++; $display("FAIL reset dut1: got %h expected %h", obs1(), exp1());
      end
      n_cmp++;
      if ({hs0, vs0, hs1, vs1} !== 4'b1100) begin
         n_err++; $display("FAIL reset_sync_levels: got %b expected 1100", {hs0, vs0, hs1, vs1});
      end
      rst = 1'b0;
   endtask

   task automatic test_line();
      en = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         tick();
         n_cmp++;
         if (obs0() !== exp0()) begin
            n_err++; $display("FAIL line dut0 edge%0d: got %h expected %h", e, obs0(), exp0());
         end
         n_cmp++;
         if (obs1() !== exp1()) begin
            n_err++; $display("FAIL line dut1 edge%0d: got %h expected %h", e, obs1(), exp1());
         end
         if (e == 1) begin
            n_cmp++;
            if ({x0, y0, de0, sol0, sof0} !== {4'd0, 4'd0, 3'b111}) begin
               n_err++; $display("FAIL first_pixel: got %h expected %h", {x0, y0, de0, sol0, sof0}, {4'd0, 4'd0, 3'b111});
            end
         end
         if (e == 5) begin
            n_cmp++;
            if ({x0, de0} !== {4'd4, 1'b0}) begin
               n_err++; $display("FAIL de_falls: got x=%0d de=%b expected x=4 de=0", x0, de0);
            end
         end
         if (e == 6 || e == 7) begin
            n_cmp++;
            if ({hs0, hs1} !== 2'b01) begin
               n_err++; $display("FAIL hsync_active edge%0d: got %b expected 01", e, {hs0, hs1});
            end
         end
         if (e == 9) begin
            n_cmp++;
            if ({x0, y0, sol0, sof0} !== {4'd0, 4'd1, 2'b10}) begin
               n_err++; $display("FAIL line_wrap: got %h expected %h", {x0, y0, sol0, sof0}, {4'd0, 4'd1, 2'b10});
            end
         end
      end
   endtask

   task automatic test_frame();
      int vs_n = 0;
      int eof_n = 0;
      for (int e = 10; e <= 49; e++) begin
         tick();
         n_cmp++;
         if (obs0() !== exp0()) begin
            n_err++; $display("FAIL frame dut0 edge%0d: got %h expected %h", e, obs0(), exp0());
         end
         n_cmp++;
         if (obs1() !== exp1()) begin
            n_err++; $display("FAIL frame dut1 edge%0d: got %h expected %h", e, obs1(), exp1());
         end
         if (vs0 === 1'b0) vs_n++;
         if (eof0 === 1'b1) eof_n++;
         if (e == 48) begin
            n_cmp++;
            if ({eof0, x0, y0} !== {1'b1, 4'd7, 4'd5}) begin
               n_err++; $display("FAIL eof_pos: got %h expected %h", {eof0, x0, y0}, {1'b1, 4'd7, 4'd5});
            end
         end
         if (e == 49) begin
            n_cmp++;
            if ({x0, y0, sof0, fc0, fc1} !== {4'd0, 4'd0, 1'b1, 16'd1, 2'd1}) begin
               n_err++; $display("FAIL frame_wrap: got %h expected %h", {x0, y0, sof0, fc0, fc1}, {4'd0, 4'd0, 1'b1, 16'd1, 2'd1});
            end
         end
      end
      n_cmp++;
      if (vs_n != 8) begin
         n_err++; $display("FAIL vsync_lines: got %0d pixels expected 8", vs_n);
      end
      n_cmp++;
      if (eof_n != 1) begin
         n_err++; $display("FAIL eof_count: got %0d expected 1", eof_n);
      end
   endtask

   task automatic test_enable_hold();
      logic [29:0] s0;
      logic [13:0] s1;
      en = 1'b1;
      while (pix != 10) tick();
      s0 = obs0();
      s1 = obs1();
      en = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_cmp++;
         if (obs0() !== s0 || obs0() !== exp0()) begin
            n_err++; $display("FAIL hold dut0 cyc%0d: got %h expected %h", c, obs0(), s0);
         end
         n_cmp++;
         if (obs1() !== s1) begin
            n_err++; $display("FAIL hold dut1 cyc%0d: got %h expected %h", c, obs1(), s1);
         end
      end
      en = 1'b1;
      tick();
      n_cmp++;
      if ({x0, y0, x1, y1} !== {4'd3, 4'd1, 3'd3, 3'd1}) begin
         n_err++; $display("FAIL resume: got x=%0d y=%0d expected x=3 y=1", x0, y0);
      end
   endtask

   task automatic test_restart();
      logic [15:0] fc_before;
      en = 1'b1;
      while (pix != 38) tick();
      fc_before = fc0;
      en = 1'b0; restart = 1'b1;
      tick();
      n_cmp++;
      if ({x0, y0, de0, hs0, vs0, sof0, fc0} !== {4'd0, 4'd0, 3'b011, 1'b0, fc_before}) begin
         n_err++; $display("FAIL restart_idle: got %h expected %h", {x0, y0, de0, hs0, vs0, sof0, fc0}, {4'd0, 4'd0, 3'b011, 1'b0, fc_before});
      end
      n_cmp++;
      if (obs1() !== exp1()) begin
         n_err++; $display("FAIL restart_idle dut1: got %h expected %h", obs1(), exp1());
      end
      restart = 1'b0; en = 1'b1;
      tick();
      n_cmp++;
      if ({x0, y0, de0, sof0, fc0} !== {4'd0, 4'd0, 2'b11, fc_before}) begin
         n_err++; $display("FAIL restart_resume: got %h expected %h", {x0, y0, de0, sof0, fc0}, {4'd0, 4'd0, 2'b11, fc_before});
      end
   endtask

   task automatic test_async_reset();
      en = 1'b1;
      tick();
      tick();
      #2;
      rst = 1'b1;
      running = 1'b0;
      frames  = 0;
      #1;
      n_cmp++;
      if (obs0() !== exp0() || fc0 !== 16'd0) begin
         n_err++; $display("FAIL async_reset dut0: got %h expected %h", obs0(), exp0());
      end
      n_cmp++;
      if (obs1() !== exp1()) begin
         n_err++; $display("FAIL async_reset dut1: got %h expected %h", obs1(), exp1());
      end
      rst = 1'b0;
   endtask

   task automatic test_frame_count();
      logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      en = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < NPIX; c++) begin
            tick();
            n_cmp++;
            if (obs0() !== exp0() || obs1() !== exp1()) begin
               n_err++; $display("FAIL fcount k%0d c%0d: got %h/%h expected %h/%h", k, c, obs0(), obs1(), exp0(), exp1());
            end
         end
         n_cmp++;
         if (fc1 !== seq[k] || fc0 !== 16'(k + 1)) begin
            n_err++; $display("FAIL frame_cnt_seq %0d: got %0d/%0d expected %0d/%0d", k, fc1, fc0, seq[k], k + 1);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         en      = ($urandom_range(0, 3) != 0);
         restart = ($urandom_range(0, 39) == 0);
         tick();
         n_cmp++;
         if (obs0() !== exp0()) begin
            n_err++; $display("FAIL random dut0 cyc%0d: got %h expected %h", c, obs0(), exp0());
         end
         n_cmp++;
         if (obs1() !== exp1()) begin
            n_err++; $display("FAIL random dut1 cyc%0d: got %h expected %h", c, obs1(), exp1());
         end
      end
      restart = 1'b0;
   endtask

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_enable_hold();
      test_restart();
      test_async_reset();
      test_frame_count();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
